// File: rtl/storage_readout_scanner_if.sv
// Bundle of the scanner's command, storage-inquiry and hit-stream signals.
//   master : the scanner side (drives inquiry, hit stream, status).
//   slave  : the environment side (storage model, command source, hit sink).
// Ports grouped here:
//   startScan, clearOnDone, abortScan      command inputs to the scanner
//   storageReady, storedValue              storage handshake/read data
//   inquiry, inquiryWordIndex/LetterIndex  read strobe and address to storage
//   clearStorage                           one-cycle clear pulse to storage
//   hitValid, hitReady, hitWord/LetterIndex  hit address stream
//   scanBusy, scanDone, hitCount           status
interface storage_readout_scanner_if #(
    parameter int WORDINDEXBITS   = 4,
    parameter int LETTERINDEXBITS = 3,
    parameter int HITCOUNTBITS    = 8
);
    logic                       startScan;
    logic                       clearOnDone;
    logic                       abortScan;
    logic                       storageReady;
    logic                       storedValue;
    logic                       inquiry;
    logic [WORDINDEXBITS-1:0]   inquiryWordIndex;
    logic [LETTERINDEXBITS-1:0] inquiryLetterIndex;
    logic                       clearStorage;
    logic                       hitValid;
    logic                       hitReady;
    logic [WORDINDEXBITS-1:0]   hitWordIndex;
    logic [LETTERINDEXBITS-1:0] hitLetterIndex;
    logic                       scanBusy;
    logic                       scanDone;
    logic [HITCOUNTBITS-1:0]    hitCount;

    modport master (
        input  startScan, clearOnDone, abortScan, storageReady, storedValue, hitReady,
        output inquiry, inquiryWordIndex, inquiryLetterIndex, clearStorage,
               hitValid, hitWordIndex, hitLetterIndex, scanBusy, scanDone, hitCount
    );

    modport slave (
        output startScan, clearOnDone, abortScan, storageReady, storedValue, hitReady,
        input  inquiry, inquiryWordIndex, inquiryLetterIndex, clearStorage,
               hitValid, hitWordIndex, hitLetterIndex, scanBusy, scanDone, hitCount
    );
endinterface

// File: rtl/storage_readout_scanner.sv
// Sequential reader for the bit-array storage. On startScan it walks every
// (word, letter) position in ascending order through the storage inquiry
// port, presents each position holding a 1 on the hit valid/ready stream,
// counts accepted hits (saturating), and at the end of a full scan pulses
// scanDone and optionally clearStorage.
// Ports:
//   clock  single clock, posedge
//   reset  synchronous, active-high, highest priority
//   bus    storage_readout_scanner_if.master (commands, storage inquiry,
//          hit stream, status)
module storage_readout_scanner #(
    parameter int WORDINDEXBITS   = 4,
    parameter int LETTERINDEXBITS = 3,
    parameter int MEMORYDEPTH     = 16,
    parameter int WORDLENGTH      = 8,
    parameter int HITCOUNTBITS    = 8
) (
    input  logic clock,
    input  logic reset,
    storage_readout_scanner_if.master bus
);

    localparam logic [WORDINDEXBITS-1:0]   LASTWORD   = WORDINDEXBITS'(MEMORYDEPTH - 1);
    localparam logic [LETTERINDEXBITS-1:0] LASTLETTER = LETTERINDEXBITS'(WORDLENGTH - 1);
    localparam logic [HITCOUNTBITS-1:0]    MAXCOUNT   = '1;

    typedef enum logic [2:0] {IDLE, QUERY, CHECK, HIT, DONE} scanState_t;

    scanState_t state, nextState;

    logic [WORDINDEXBITS-1:0]   wordIndex;
    logic [LETTERINDEXBITS-1:0] letterIndex;
    logic [WORDINDEXBITS-1:0]   hitWord;
    logic [LETTERINDEXBITS-1:0] hitLetter;
    logic [HITCOUNTBITS-1:0]    hitCounter;
    logic                       clearLatched;
    logic                       queryActive;
    logic                       hitValidReg;
    logic                       busyReg;
    logic                       doneReg;
    logic                       clearReg;

    logic lastPosition;
    logic doStart;
    logic doAdvance;
    logic doLoadHit;
    logic doCount;

    assign lastPosition = (wordIndex == LASTWORD) && (letterIndex == LASTLETTER);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and datapath control
    always_comb begin
        nextState = state;
        doStart   = 1'b0;
        doAdvance = 1'b0;
        doLoadHit = 1'b0;
        doCount   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.startScan) begin
                    doStart   = 1'b1;
                    nextState = QUERY;
                end
            end
            QUERY: begin
                if (bus.storageReady) begin
                    nextState = CHECK;
                end
            end
            CHECK: begin
                if (bus.storedValue) begin
                    doLoadHit = 1'b1;
                    nextState = HIT;
                end else begin
                    doAdvance = 1'b1;
                    nextState = lastPosition ? DONE : QUERY;
                end
            end
            HIT: begin
                if (bus.hitReady) begin
                    doCount   = 1'b1;
                    doAdvance = 1'b1;
                    nextState = lastPosition ? DONE : QUERY;
                end
            end
            DONE: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
        // Abort overrides everything, including a hit handshake in this cycle.
        if (bus.abortScan && (state != IDLE)) begin
            nextState = IDLE;
            doAdvance = 1'b0;
            doLoadHit = 1'b0;
            doCount   = 1'b0;
        end
    end

    // Address counters, hit registers, counter and registered status flags.
    // Flags are computed from nextState so they line up with the state they
    // describe in the following cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            wordIndex    <= '0;
            letterIndex  <= '0;
            hitWord      <= '0;
            hitLetter    <= '0;
            hitCounter   <= '0;
            clearLatched <= 1'b0;
            queryActive  <= 1'b0;
            hitValidReg  <= 1'b0;
            busyReg      <= 1'b0;
            doneReg      <= 1'b0;
            clearReg     <= 1'b0;
        end else begin
            queryActive <= (nextState == QUERY);
            hitValidReg <= (nextState == HIT);
            busyReg     <= (nextState != IDLE);
            doneReg     <= (nextState == DONE);
            clearReg    <= (nextState == DONE) && clearLatched;

            if (doStart) begin
                wordIndex    <= '0;
                letterIndex  <= '0;
                hitCounter   <= '0;
                clearLatched <= bus.clearOnDone;
            end

            if (doLoadHit) begin
                hitWord   <= wordIndex;
                hitLetter <= letterIndex;
            end

            if (doCount && (hitCounter != MAXCOUNT)) begin
                hitCounter <= hitCounter + 1'b1;
            end

            if (doAdvance) begin
                if (letterIndex == LASTLETTER) begin
                    letterIndex <= '0;
                    wordIndex   <= wordIndex + 1'b1;
                end else begin
                    letterIndex <= letterIndex + 1'b1;
                end
            end
        end
    end

    // The strobe is gated by storageReady so a stalled QUERY issues nothing;
    // the indices come straight from the counters, which only move outside QUERY.
    assign bus.inquiry            = queryActive & bus.storageReady;
    assign bus.inquiryWordIndex   = wordIndex;
    assign bus.inquiryLetterIndex = letterIndex;
    assign bus.clearStorage       = clearReg;
    assign bus.hitValid           = hitValidReg;
    assign bus.hitWordIndex       = hitWord;
    assign bus.hitLetterIndex     = hitLetter;
    assign bus.scanBusy           = busyReg;
    assign bus.scanDone           = doneReg;
    assign bus.hitCount           = hitCounter;

endmodule

// File: tb/tb_storage_readout_scanner.sv
module tb_storage_readout_scanner;
    localparam int WIB  = 4;
    localparam int LIB  = 3;
    localparam int WLEN = 8;
    localparam int NPOS = 128;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    storage_readout_scanner_if #(.WORDINDEXBITS(WIB), .LETTERINDEXBITS(LIB), .HITCOUNTBITS(8)) scanBus ();

    storage_readout_scanner #(
        .WORDINDEXBITS(WIB), .LETTERINDEXBITS(LIB), .MEMORYDEPTH(16),
        .WORDLENGTH(WLEN), .HITCOUNTBITS(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (scanBus)
    );

    int total = 0;
    int bad   = 0;

    bit mem [NPOS];

    // run configuration
    int hrMode;        // 0: hitReady always 1, 1: high on even cycles, 2: random
    int srStallStart;
    int srStallLen;
    bit srRandom;
    bit clrVal;
    bit startNoise;
    int abortAtHit;
    int resetAtHit;

    // observations of one run
    int inqPos[$];
    int inqCyc[$];
    int hitPos[$];
    int firstHitCyc, firstHitPos;
    int doneCnt, doneCyc, clrCnt, clrCyc, busyCnt, unstable;
    int eventCyc, idleAt, finalCount;
    bit timedOut;
    logic [4:0] snapFlags;   // {inquiry, clearStorage, hitValid, scanBusy, scanDone}
    logic [13:0] snapIdx;
    logic [7:0] snapCount;

    task automatic cfg_defaults();
        hrMode = 0; srStallStart = -100; srStallLen = 0; srRandom = 0;
        clrVal = 0; startNoise = 0; abortAtHit = -1; resetAtHit = -1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < NPOS; i++) mem[i] = 1'b0;
    endtask

    task automatic set_random_bits(input int n);
        int cnt;
        int p;
        clear_mem();
        cnt = 0;
        while (cnt < n) begin
            p = $urandom_range(0, NPOS - 1);
            if (!mem[p]) begin mem[p] = 1'b1; cnt++; end
        end
    endtask

    // Cycle at which scanDone is expected, from the per-position cost rules.
    function automatic int model_done(input int mode, input int sStart, input int sLen);
        int t, q, h;
        t = 0;
        for (int k = 0; k < NPOS; k++) begin
            q = t + 1;
            while (q >= sStart && q < sStart + sLen) q++;
            t = q + 1;
            if (mem[k]) begin
                h = t + 1;
                while (mode == 1 && (h % 2) != 0) h++;
                t = h;
            end
        end
        return t + 1;
    endfunction

    // Drives one scan (startScan in cycle 0) acting as storage model and hit
    // sink, and records what the DUT presented. No checking here.
    task automatic run_scan(input int budget);
        bit lastInq, prevHv, prevAcc, prevBusy, prevDone, acc;
        int lastPos, prevHitPos, pos;
        inqPos.delete(); inqCyc.delete(); hitPos.delete();
        firstHitCyc = -1; firstHitPos = -1; doneCnt = 0; doneCyc = -1;
        clrCnt = 0; clrCyc = -1; busyCnt = 0; unstable = 0; eventCyc = -1; idleAt = -1;
        snapFlags = '1; snapIdx = '1; snapCount = '1;
        lastInq = 0; lastPos = 0; prevHv = 0; prevAcc = 0; prevHitPos = -1;
        prevBusy = 0; prevDone = 0;
        for (int c = 0; c < budget; c++) begin
            @(posedge clock); #1;
            reset = 1'b0;
            scanBus.startScan   = (c == 0) || (startNoise && prevBusy && !prevDone && ($urandom_range(0, 1) == 1));
            scanBus.clearOnDone = (c == 0) ? clrVal : 1'($urandom_range(0, 1));
            scanBus.storedValue = lastInq ? mem[lastPos] : 1'($urandom_range(0, 1));
            if (c >= srStallStart && c < srStallStart + srStallLen) scanBus.storageReady = 1'b0;
            else if (srRandom) scanBus.storageReady = ($urandom_range(0, 3) != 0);
            else scanBus.storageReady = 1'b1;
            case (hrMode)
                0: scanBus.hitReady = 1'b1;
                1: scanBus.hitReady = ((c % 2) == 0);
                default: scanBus.hitReady = 1'($urandom_range(0, 1));
            endcase
            scanBus.abortScan = 1'b0;
            if (scanBus.hitValid && eventCyc < 0) begin
                if (hitPos.size() == abortAtHit) begin
                    scanBus.abortScan = 1'b1; scanBus.hitReady = 1'b1; eventCyc = c;
                end else if (hitPos.size() == resetAtHit) begin
                    reset = 1'b1; eventCyc = c;
                end
            end
            @(negedge clock);
            lastInq = scanBus.inquiry;
            lastPos = int'(scanBus.inquiryWordIndex) * WLEN + int'(scanBus.inquiryLetterIndex);
            if (scanBus.inquiry) begin inqPos.push_back(lastPos); inqCyc.push_back(c); end
            if (scanBus.hitValid) begin
                pos = int'(scanBus.hitWordIndex) * WLEN + int'(scanBus.hitLetterIndex);
                if (firstHitCyc < 0) begin firstHitCyc = c; firstHitPos = pos; end
                if (prevHv && !prevAcc && pos != prevHitPos) unstable++;
                acc = scanBus.hitReady && !scanBus.abortScan && !reset;
                if (acc) hitPos.push_back(pos);
                prevHv = 1; prevAcc = acc; prevHitPos = pos;
            end else begin
                prevHv = 0;
            end
            if (scanBus.scanDone) begin doneCnt++; doneCyc = c; end
            if (scanBus.clearStorage) begin clrCnt++; clrCyc = c; end
            if (scanBus.scanBusy) busyCnt++;
            if (eventCyc >= 0 && c == eventCyc + 1) begin
                snapFlags = {scanBus.inquiry, scanBus.clearStorage, scanBus.hitValid, scanBus.scanBusy, scanBus.scanDone};
                snapIdx   = {scanBus.inquiryWordIndex, scanBus.inquiryLetterIndex, scanBus.hitWordIndex, scanBus.hitLetterIndex};
                snapCount = scanBus.hitCount;
            end
            prevBusy = scanBus.scanBusy; prevDone = scanBus.scanDone;
            if (c > 0 && !scanBus.scanBusy && idleAt < 0) idleAt = c;
            if (idleAt >= 0 && c >= idleAt + 3) break;
        end
        timedOut   = (idleAt < 0);
        finalCount = int'(scanBus.hitCount);
        scanBus.startScan = 1'b0; scanBus.abortScan = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        scanBus.startScan = 0; scanBus.clearOnDone = 0; scanBus.abortScan = 0;
        scanBus.storageReady = 1; scanBus.storedValue = 0; scanBus.hitReady = 1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        total++; if ({scanBus.inquiry, scanBus.clearStorage, scanBus.hitValid, scanBus.scanBusy, scanBus.scanDone} !== 5'b0) begin bad++; $display("FAIL reset_flags got=%b want=00000", {scanBus.inquiry, scanBus.clearStorage, scanBus.hitValid, scanBus.scanBusy, scanBus.scanDone}); end
        total++; if ({scanBus.inquiryWordIndex, scanBus.inquiryLetterIndex, scanBus.hitWordIndex, scanBus.hitLetterIndex} !== 14'b0) begin bad++; $display("FAIL reset_indices got=%h want=0", {scanBus.inquiryWordIndex, scanBus.inquiryLetterIndex, scanBus.hitWordIndex, scanBus.hitLetterIndex}); end
        total++; if (scanBus.hitCount !== 8'd0) begin bad++; $display("FAIL reset_hitCount got=%0d want=0", scanBus.hitCount); end
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        total++; if (scanBus.scanBusy !== 1'b0) begin bad++; $display("FAIL reset_idle_busy got=%b want=0", scanBus.scanBusy); end
    endtask

    task automatic test_empty();
        int orderErr, cycErr;
        cfg_defaults(); clear_mem();
        run_scan(3000);
        orderErr = 0; cycErr = 0;
        for (int i = 0; i < inqPos.size() && i < NPOS; i++) begin
            if (inqPos[i] != i) orderErr++;
            if (inqCyc[i] != 2 * i + 1) cycErr++;
        end
        total++; if (timedOut !== 1'b0) begin bad++; $display("FAIL empty_timeout got=%b want=0", timedOut); end
        total++; if (inqPos.size() !== NPOS) begin bad++; $display("FAIL empty_inquiries got=%0d want=%0d", inqPos.size(), NPOS); end
        total++; if (orderErr !== 0) begin bad++; $display("FAIL empty_order got=%0d errors want=0", orderErr); end
        total++; if (cycErr !== 0) begin bad++; $display("FAIL empty_inq_cycles got=%0d errors want=0", cycErr); end
        total++; if (firstHitCyc !== -1) begin bad++; $display("FAIL empty_no_hit got=%0d want=-1", firstHitCyc); end
        total++; if (doneCnt !== 1 || doneCyc !== 257) begin bad++; $display("FAIL empty_done got=%0d@%0d want=1@257", doneCnt, doneCyc); end
        total++; if (doneCyc !== model_done(0, -100, 0)) begin bad++; $display("FAIL empty_done_model got=%0d want=%0d", doneCyc, model_done(0, -100, 0)); end
        total++; if (idleAt !== 258 || busyCnt !== 257) begin bad++; $display("FAIL empty_busy got=idle%0d/busy%0d want=258/257", idleAt, busyCnt); end
        total++; if (finalCount !== 0 || clrCnt !== 0) begin bad++; $display("FAIL empty_count_clear got=%0d/%0d want=0/0", finalCount, clrCnt); end
    endtask

    task automatic test_single();
        cfg_defaults(); clear_mem(); mem[3 * WLEN + 5] = 1'b1;
        run_scan(3000);
        total++; if (timedOut !== 1'b0) begin bad++; $display("FAIL single_timeout got=%b want=0", timedOut); end
        total++; if (inqCyc.size() < 30 || inqCyc[29] !== 59) begin bad++; $display("FAIL single_query29 got=%0d want=59", (inqCyc.size() > 29) ? inqCyc[29] : -1); end
        total++; if (firstHitCyc !== 61 || firstHitPos !== 29) begin bad++; $display("FAIL single_hit got=pos%0d@%0d want=pos29@61", firstHitPos, firstHitCyc); end
        total++; if (doneCyc !== 258 || doneCnt !== 1) begin bad++; $display("FAIL single_done got=%0d@%0d want=1@258", doneCnt, doneCyc); end
        total++; if (finalCount !== 1 || hitPos.size() !== 1) begin bad++; $display("FAIL single_count got=%0d/%0d want=1/1", finalCount, hitPos.size()); end
    endtask

    task automatic test_all_toggle();
        int orderErr;
        cfg_defaults(); hrMode = 1;
        for (int i = 0; i < NPOS; i++) mem[i] = 1'b1;
        run_scan(3000);
        orderErr = 0;
        for (int i = 0; i < hitPos.size(); i++) if (hitPos[i] != i) orderErr++;
        total++; if (hitPos.size() !== NPOS || orderErr !== 0) begin bad++; $display("FAIL toggle_hits got=%0d hits %0d misordered want=128/0", hitPos.size(), orderErr); end
        total++; if (unstable !== 0) begin bad++; $display("FAIL toggle_stable got=%0d changes want=0", unstable); end
        total++; if (finalCount !== 128) begin bad++; $display("FAIL toggle_count got=%0d want=128", finalCount); end
        total++; if (doneCnt !== 1 || doneCyc !== model_done(1, -100, 0)) begin bad++; $display("FAIL toggle_done got=%0d@%0d want=1@%0d", doneCnt, doneCyc, model_done(1, -100, 0)); end
    endtask

    task automatic test_stall();
        int orderErr;
        cfg_defaults(); clear_mem(); srStallStart = 21; srStallLen = 5;
        run_scan(3000);
        orderErr = 0;
        for (int i = 0; i < inqPos.size(); i++) if (inqPos[i] != i) orderErr++;
        total++; if (inqPos.size() !== NPOS || orderErr !== 0) begin bad++; $display("FAIL stall_order got=%0d inq %0d misordered want=128/0", inqPos.size(), orderErr); end
        total++; if (inqCyc.size() < 11 || inqCyc[9] !== 19 || inqCyc[10] !== 26) begin bad++; $display("FAIL stall_gap got=%0d,%0d want=19,26", (inqCyc.size() > 9) ? inqCyc[9] : -1, (inqCyc.size() > 10) ? inqCyc[10] : -1); end
        total++; if (doneCyc !== model_done(0, 21, 5) || doneCyc !== 262) begin bad++; $display("FAIL stall_done got=%0d want=262", doneCyc); end
    endtask

    task automatic test_clear();
        cfg_defaults(); clrVal = 1; set_random_bits(3);
        run_scan(3000);
        total++; if (clrCnt !== 1 || clrCyc !== doneCyc) begin bad++; $display("FAIL clear_pulse got=%0d@%0d want=1@%0d", clrCnt, clrCyc, doneCyc); end
        total++; if (doneCnt !== 1 || doneCyc !== model_done(0, -100, 0)) begin bad++; $display("FAIL clear_done got=%0d@%0d want=1@%0d", doneCnt, doneCyc, model_done(0, -100, 0)); end
        total++; if (finalCount !== 3) begin bad++; $display("FAIL clear_count got=%0d want=3", finalCount); end
    endtask

    task automatic test_abort();
        int expHits[$];
        int listErr;
        cfg_defaults(); clrVal = 1; abortAtHit = 3; set_random_bits(8);
        for (int k = 0; k < NPOS; k++) if (mem[k]) expHits.push_back(k);
        run_scan(3000);
        listErr = 0;
        for (int i = 0; i < hitPos.size() && i < expHits.size(); i++) if (hitPos[i] != expHits[i]) listErr++;
        total++; if (eventCyc < 0 || snapFlags !== 5'b0) begin bad++; $display("FAIL abort_next got=ev%0d flags=%b want=idle flags 00000", eventCyc, snapFlags); end
        total++; if (doneCnt !== 0 || clrCnt !== 0) begin bad++; $display("FAIL abort_pulses got=%0d/%0d want=0/0", doneCnt, clrCnt); end
        total++; if (finalCount !== 3 || snapCount !== 8'd3) begin bad++; $display("FAIL abort_count got=%0d/%0d want=3", finalCount, snapCount); end
        total++; if (hitPos.size() !== 3 || listErr !== 0) begin bad++; $display("FAIL abort_hits got=%0d (%0d wrong) want=3", hitPos.size(), listErr); end
    endtask

    task automatic test_reset_hit();
        int expHits[$];
        int listErr;
        cfg_defaults(); resetAtHit = 2; set_random_bits(6);
        for (int k = 0; k < NPOS; k++) if (mem[k]) expHits.push_back(k);
        run_scan(3000);
        total++; if (eventCyc < 0 || snapFlags !== 5'b0 || snapIdx !== 14'b0 || snapCount !== 8'd0) begin bad++; $display("FAIL rsthit_state got=ev%0d %b/%h/%0d want=all zero", eventCyc, snapFlags, snapIdx, snapCount); end
        cfg_defaults();
        run_scan(3000);
        listErr = 0;
        for (int i = 0; i < hitPos.size() && i < expHits.size(); i++) if (hitPos[i] != expHits[i]) listErr++;
        total++; if (inqPos.size() !== NPOS || inqPos[0] !== 0 || inqCyc[0] !== 1) begin bad++; $display("FAIL rsthit_rescan got=%0d inq first=%0d want=128 first=0", inqPos.size(), (inqPos.size() > 0) ? inqPos[0] : -1); end
        total++; if (hitPos.size() !== 6 || listErr !== 0 || finalCount !== 6) begin bad++; $display("FAIL rsthit_hits got=%0d (%0d wrong) count=%0d want=6", hitPos.size(), listErr, finalCount); end
    endtask

    task automatic test_random();
        int expHits[$];
        int orderErr, listErr, density;
        for (int it = 0; it < 4; it++) begin
            cfg_defaults(); hrMode = 2; srRandom = 1; startNoise = 1;
            clrVal = 1'($urandom_range(0, 1));
            density = $urandom_range(0, 100);
            expHits.delete();
            for (int k = 0; k < NPOS; k++) begin
                mem[k] = ($urandom_range(0, 99) < density);
                if (mem[k]) expHits.push_back(k);
            end
            run_scan(4000);
            orderErr = 0; listErr = 0;
            for (int i = 0; i < inqPos.size(); i++) if (inqPos[i] != i) orderErr++;
            for (int i = 0; i < hitPos.size() && i < expHits.size(); i++) if (hitPos[i] != expHits[i]) listErr++;
            total++; if (timedOut !== 1'b0 || inqPos.size() !== NPOS || orderErr !== 0) begin bad++; $display("FAIL random%0d_walk got=to%b %0d inq %0d misordered want=128/0", it, timedOut, inqPos.size(), orderErr); end
            total++; if (hitPos.size() !== expHits.size() || listErr !== 0) begin bad++; $display("FAIL random%0d_hits got=%0d (%0d wrong) want=%0d", it, hitPos.size(), listErr, expHits.size()); end
            total++; if (unstable !== 0 || finalCount !== expHits.size()) begin bad++; $display("FAIL random%0d_count got=%0d unstable=%0d want=%0d", it, finalCount, unstable, expHits.size()); end
            total++; if (doneCnt !== 1 || clrCnt !== int'(clrVal)) begin bad++; $display("FAIL random%0d_done got=%0d/%0d want=1/%0d", it, doneCnt, clrCnt, clrVal); end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cfg_defaults();
        test_reset();
        test_empty();
        test_single();
        test_all_toggle();
        test_stall();
        test_clear();
        test_abort();
        test_reset_hit();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/storage_readout_scanner.md
# storage_readout_scanner

Sequential reader for the bit-array memory storage. On command it walks every (word, letter) position through the storage inquiry port. It reports each position holding a 1 as a hit on a valid/ready stream to downstream pattern logic, and counts the hits. When the scan completes it can optionally pulse the storage clear. It is the read-side counterpart of the address-writing path: the writer sets bits via newAddress, and this block drains them.

## Interface
- WORDINDEXBITS, 4, width of word index
- LETTERINDEXBITS, 3, width of letter index
- MEMORYDEPTH, 16, number of words scanned (≤ 2^WORDINDEXBITS)
- WORDLENGTH, 8, letters per word (≤ 2^LETTERINDEXBITS)
- HITCOUNTBITS, 8, width of hit counter
- clock  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high
- startScan  in  1  begin scan; sampled only in IDLE
- clearOnDone  in  1  latched with startScan; request clearStorage pulse at end of scan
- abortScan  in  1  terminate scan; valid in any non-IDLE state
- storageReady  in  1  storage can accept an inquiry
- storedValue  in  1  storage read data, valid in the cycle after inquiry
- inquiry  out  1  read strobe to storage
- inquiryWordIndex  out  WORDINDEXBITS  word being read
- inquiryLetterIndex  out  LETTERINDEXBITS  letter being read
- clearStorage  out  1  one-cycle clear pulse to storage
- hitValid  out  1  hit address presented
- hitReady  in  1  downstream accepts hit
- hitWordIndex  out  WORDINDEXBITS  word of the hit
- hitLetterIndex  out  LETTERINDEXBITS  letter of the hit
- scanBusy  out  1  high in every state except IDLE
- scanDone  out  1  one-cycle pulse on normal completion
- hitCount  out  HITCOUNTBITS  hits found in the current or most recent scan

## Operation
- States: IDLE, QUERY, CHECK, HIT, DONE.
- IDLE, startScan=1:
  - Zero the address counters and hitCount.
  - Latch clearOnDone.
  - Move to QUERY.
  - startScan in any other state is ignored.
- QUERY:
  - If storageReady=1, drive inquiry=1 with the current indices for exactly one cycle, then move to CHECK.
  - If storageReady=0, hold inquiry=0 and stay in QUERY.
- CHECK:
  - Sample storedValue.
  - If storedValue=1, load the hit registers with the current indices and move to HIT.
  - Otherwise advance the address.
- HIT:
  - hitValid=1; hitWordIndex and hitLetterIndex are held stable until the handshake (hitValid & hitReady).
  - On the handshake, increment hitCount, then advance the address.
- Advance:
  - The letter index increments first.
  - At letter WORDLENGTH-1 the letter index wraps to 0 and the word index increments.
  - If the position just finished is (MEMORYDEPTH-1, WORDLENGTH-1), go to DONE; otherwise go to QUERY.
- DONE, one cycle:
  - scanDone=1.
  - clearStorage=1 if clearOnDone was latched.
  - Then go to IDLE.
- hitCount saturates at 2^HITCOUNTBITS-1. It keeps its value in IDLE until the next accepted startScan.
- abortScan:
  - Next state is IDLE; any pending hitValid is dropped.
  - No scanDone or clearStorage pulse.
  - hitCount keeps its partial value.
  - abortScan takes priority over every transition, including a simultaneous hit handshake (that hit is not counted).
- reset has priority over everything. All outputs return to their reset values and the state returns to IDLE.

## Timing
- Reset values:
  - inquiry, clearStorage, hitValid, scanBusy, scanDone = 0.
  - All indices = 0; hitCount = 0.
- Per-position cost with storageReady=1:
  - 2 cycles (QUERY + CHECK) for a 0.
  - 3 cycles (plus HIT) for a 1 with hitReady=1.
  - Each extra cycle of hitReady=0 adds 1 cycle.
- Cycle numbering: startScan is high in cycle 0 (IDLE). Position k = word·WORDLENGTH + letter is in QUERY at cycle 2k+1 and CHECK at 2k+2, plus preceding hit and stall cycles.
- Empty memory at default parameters: DONE/scanDone in cycle 257; IDLE in cycle 258.
- Outputs are registered. Inquiry indices are stable for the whole QUERY cycle.

## Test plan
- Empty memory, defaults, hitReady=1, startScan pulse in cycle 0:
  - 128 inquiry pulses.
  - No hitValid.
  - scanDone only in cycle 257.
  - hitCount=0.
- Single bit at word 3, letter 5:
  - CHECK in cycle 60, hitValid in cycle 61 with indices (3,5).
  - scanDone in cycle 258.
  - hitCount=1.
- All bits set, hitReady toggled 1/0 each cycle:
  - 128 hits emitted in ascending order (0,0)…(15,7).
  - Indices stable while hitReady=0.
  - hitCount=128.
- storageReady held low for 5 cycles during QUERY of position 10:
  - inquiry stays 0 for those cycles.
  - The scan resumes at position 10 with no position skipped.
- clearOnDone=1 with 3 bits set: clearStorage pulses together with scanDone for exactly one cycle. Abort case: abortScan asserted during HIT with hitReady=1:
  - IDLE next cycle.
  - No scanDone or clearStorage pulse.
  - hitCount excludes that hit.
- reset during HIT: next cycle all outputs are at their reset values; a following startScan rescans from (0,0).
